calculator_ctrl: RTL and testbench

Control and arithmetic stage of the calculator, directly downstream of the button input stage. Consumes the debounced, synchronised `button_ent`/`button_clr` levels plus operand/operator switches. Sequences operand A → operand B → operator → result, computes the result (add, sub, mul, iterative div), and drives the value to display plus status flags.

---
 rtl/calculator_pkg.sv | 19 +
 rtl/calculator_div.sv | 60 ++++++
 rtl/calculator_ctrl.sv | 164 ++++++++++++++++
 tb/tb_calculator_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/calculator_pkg.sv
// Shared types for the calculator control stage: FSM states and operator encodings.
package calculator_pkg;

  typedef enum logic [2:0] {
    S_OPA,
    S_OPB,
    S_OP,
    S_CALC,
    S_RES
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

endpackage

// File: rtl/calculator_div.sv
// Restoring unsigned divider: one quotient bit per cycle, done pulses the cycle after the last bit.
module calculator_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;
  logic             running;
  logic [WIDTH:0]   trial;

  assign trial    = {rem, dvd[WIDTH-1]};
  assign quotient = dvd;

  // dvd shifts the dividend out and the quotient bits in, so it ends holding the quotient
  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= '0;
      dvd     <= '0;
      dsr     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem     <= '0;
        dvd     <= dividend;
        dsr     <= divisor;
        cnt     <= CW'(WIDTH);
        running <= 1'b1;
      end else if (running) begin
        if (trial >= {1'b0, dsr}) begin
          rem <= WIDTH'(trial - {1'b0, dsr});
          dvd <= {dvd[WIDTH-2:0], 1'b1};
        end else begin
          rem <= trial[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calculator_ctrl.sv
// Calculator sequencing FSM: operand A -> operand B -> operator -> result, with edge-detected buttons.
//   state  | meaning
//   S_OPA  | entering operand A, display shows switches
//   S_OPB  | entering operand B, display shows switches
//   S_OP   | selecting operator, display shows operator code
//   S_CALC | computing (busy), divider running for div
//   S_RES  | result held on display until next enter
module calculator_ctrl
  import calculator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               button_ent,
  input  logic               button_clr,
  input  logic [WIDTH-1:0]   sw,
  input  logic [1:0]         sw_op,
  output logic [2*WIDTH-1:0] display,
  output logic               neg,
  output logic               err,
  output logic               busy,
  output logic [1:0]         phase
);

  localparam int RW = 2 * WIDTH;

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ent_q;
  logic             clr_q;
  logic             ent_rise;
  logic             clr_rise;
  logic             div_reset;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] quotient;
  logic [RW-1:0]    a_ext;
  logic [RW-1:0]    b_ext;
  logic [RW-1:0]    sw_ext;
  logic [RW-1:0]    op_ext;

  assign ent_rise  = button_ent & ~ent_q;
  assign clr_rise  = button_clr & ~clr_q;
  assign a_ext     = RW'(a);
  assign b_ext     = RW'(b);
  assign sw_ext    = RW'(sw);
  assign op_ext    = RW'(sw_op);
  assign div_reset = reset | clr_rise;
  // Launch the divider on the operator-enter edge so it finishes within WIDTH+1 S_CALC cycles
  assign div_start = (state == S_OP) & ent_rise & ~clr_rise &
                     (op_t'(sw_op) == OP_DIV) & (b != '0);

  calculator_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (div_reset),
    .start    (div_start),
    .dividend (a),
    .divisor  (b),
    .quotient (quotient),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_OPA;
      op      <= OP_ADD;
      a       <= '0;
      b       <= '0;
      ent_q   <= 1'b1;
      clr_q   <= 1'b1;
      display <= '0;
      neg     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      phase   <= 2'd0;
    end else begin
      ent_q <= button_ent;
      clr_q <= button_clr;
      if (clr_rise) begin
        state   <= S_OPA;
        a       <= '0;
        b       <= '0;
        display <= sw_ext;
        neg     <= 1'b0;
        err     <= 1'b0;
        busy    <= 1'b0;
        phase   <= 2'd0;
      end else begin
        case (state)
          S_OPA: begin
            display <= sw_ext;
            if (ent_rise) begin
              a     <= sw;
              state <= S_OPB;
              phase <= 2'd1;
            end
          end
          S_OPB: begin
            display <= sw_ext;
            if (ent_rise) begin
              b       <= sw;
              state   <= S_OP;
              phase   <= 2'd2;
              display <= op_ext;
            end
          end
          S_OP: begin
            display <= op_ext;
            if (ent_rise) begin
              op    <= op_t'(sw_op);
              state <= S_CALC;
              busy  <= 1'b1;
              phase <= 2'd3;
            end
          end
          S_CALC: begin
            if (op != OP_DIV || b == '0 || div_done) begin
              state <= S_RES;
              busy  <= 1'b0;
            end
            unique case (op)
              OP_ADD: display <= a_ext + b_ext;
              OP_SUB: begin
                if (a >= b) begin
                  display <= a_ext - b_ext;
                  neg     <= 1'b0;
                end else begin
                  display <= b_ext - a_ext;
                  neg     <= 1'b1;
                end
              end
              OP_MUL: display <= a_ext * b_ext;
              OP_DIV: begin
                if (b == '0) begin
                  err     <= 1'b1;
                  display <= '0;
                end else if (div_done) begin
                  display <= RW'(quotient);
                end
              end
            endcase
          end
          S_RES: begin
            if (ent_rise) begin
              state   <= S_OPA;
              phase   <= 2'd0;
              display <= sw_ext;
              neg     <= 1'b0;
              err     <= 1'b0;
            end
          end
          default: begin
            state <= S_OPA;
            phase <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calculator_ctrl.sv
// Directed bench for calculator_ctrl: scoreboard of expected results, immediate-assert checks.
module tb_calculator_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           button_ent = 1'b0;
  logic           button_clr = 1'b0;
  logic [W-1:0]   sw = '0;
  logic [1:0]     sw_op = '0;
  logic [2*W-1:0] display;
  logic           neg;
  logic           err;
  logic           busy;
  logic [1:0]     phase;

  typedef struct {
    logic [15:0] disp;
    logic        neg;
    logic        err;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  calculator_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .button_ent (button_ent),
    .button_clr (button_clr),
    .sw         (sw),
    .sw_op      (sw_op),
    .display    (display),
    .neg        (neg),
    .err        (err),
    .busy       (busy),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    e.neg    = 1'b0;
    e.err    = 1'b0;
    e.cycles = 1;
    e.disp   = '0;
    case (op)
      0: e.disp = 16'(a + b);
      1: begin
        if (a >= b) e.disp = 16'(a - b);
        else begin
          e.disp = 16'(b - a);
          e.neg  = 1'b1;
        end
      end
      2: e.disp = 16'(a * b);
      default: begin
        if (b == 0) e.err = 1'b1;
        else begin
          e.disp   = 16'(a / b);
          e.cycles = W + 1;
        end
      end
    endcase
    return e;
  endfunction

  task automatic press_ent();
    @(negedge clk) button_ent = 1'b1;
    @(negedge clk) button_ent = 1'b0;
  endtask

  task automatic press_clr();
    @(negedge clk) button_clr = 1'b1;
    @(negedge clk) button_clr = 1'b0;
  endtask

  // Leaves the bench at the first negedge inside S_CALC
  task automatic enter_calc(input int a, input int b, input int op);
    sw = W'(a);
    press_ent();
    sw = W'(b);
    press_ent();
    sw_op = 2'(op);
    @(negedge clk) button_ent = 1'b1;
    sb.push_back(model(a, b, op));
    @(negedge clk) button_ent = 1'b0;
  endtask

  task automatic collect(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check({tag, "_busy_cycles"}, n, e.cycles);
    check({tag, "_display"}, display, e.disp);
    check({tag, "_neg"}, neg, e.neg);
    check({tag, "_err"}, err, e.err);
    check({tag, "_phase"}, phase, 3);
  endtask

  initial begin
    // reset with enter held through and after it
    button_ent = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_display", display, 0);
    check("rst_neg", neg, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_phase", phase, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("ent_held_after_reset", phase, 0);
    button_ent = 1'b0;
    @(negedge clk);
    check("ent_released", phase, 0);
    sw = 8'd42;
    @(negedge clk);
    check("live_display_a", display, 42);

    // long hold produces one event only
    button_ent = 1'b1;
    repeat (50) @(negedge clk);
    check("hold_one_event", phase, 1);
    button_ent = 1'b0;
    @(negedge clk);
    check("hold_release", phase, 1);
    press_clr();
    check("clr_to_opa", phase, 0);

    enter_calc(200, 100, 0);
    collect("add");
    press_ent();
    check("res_to_opa", phase, 0);

    enter_calc(5, 9, 1);
    collect("sub_neg");
    press_ent();

    enter_calc(255, 255, 2);
    collect("mul");
    press_ent();

    enter_calc(200, 7, 3);
    collect("div");
    press_ent();

    enter_calc(13, 0, 3);
    collect("div0");
    press_ent();

    // clear aborts an in-flight division
    enter_calc(255, 1, 3);
    sw = 8'd77;
    @(negedge clk) button_clr = 1'b1;
    @(negedge clk) button_clr = 1'b0;
    void'(sb.pop_front());
    check("abort_phase", phase, 0);
    check("abort_busy", busy, 0);
    check("abort_display", display, 77);
    check("abort_err", err, 0);

    enter_calc(100, 3, 3);
    collect("div_after_abort");
    press_ent();

    // clear and enter on the same cycle in S_OPB
    sw = 8'd10;
    press_ent();
    check("opb_reached", phase, 1);
    sw = 8'd99;
    @(negedge clk) begin
      button_ent = 1'b1;
      button_clr = 1'b1;
    end
    @(negedge clk) begin
      button_ent = 1'b0;
      button_clr = 1'b0;
    end
    check("clr_wins_phase", phase, 0);
    check("clr_wins_display", display, 99);

    enter_calc(3, 4, 1);
    collect("sub_after_clr");
    press_ent();

    // reset from S_RES
    enter_calc(200, 100, 0);
    collect("add2");
    reset = 1'b1;
    @(negedge clk);
    check("res_reset_display", display, 0);
    check("res_reset_neg", neg, 0);
    check("res_reset_err", err, 0);
    check("res_reset_busy", busy, 0);
    check("res_reset_phase", phase, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
